// File: rtl/spi_ram_responder.sv
// SPI mode-0 serial RAM slave: READ (0x03) / WRITE (0x02) with a wrapping byte address.
// SPI pins are synchronised into clk and all sequencing runs on clk.
module spi_ram_responder #(
  parameter int MEM_BYTES = 16,
  parameter int ADDR_BITS = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_clk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic busy,
  output logic wr_strobe
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int CW = (ADDR_BITS > 8) ? $clog2(ADDR_BITS) : 3;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_READ, S_WRITE, S_IGNORE
  } state_t;

  state_t          state_q;
  logic [2:0]      sclk_q;
  logic [2:0]      cs_q;
  logic [1:0]      mosi_q;
  logic [CW-1:0]   cnt_q;
  logic [6:0]      sr_q;
  logic [7:0]      out_q;
  logic [AW-1:0]   addr_q;
  logic            wr_q;
  logic            load_q;
  logic            miso_q;
  logic            strobe_q;
  logic [7:0]      mem_q [MEM_BYTES];

  logic          rise;
  logic          fall;
  logic          cs_rise;
  logic          cs_fall;
  logic          last_bit;
  logic          last_addr;
  logic [7:0]    sh_d;
  logic [CW-1:0] cnt_d;

  assign rise      = sclk_q[1] & ~sclk_q[2];
  assign fall      = ~sclk_q[1] & sclk_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign last_bit  = (cnt_q == CW'(7));
  assign last_addr = (cnt_q == CW'(ADDR_BITS - 1));
  // only the low 8 bits ever matter: the command, or the address modulo MEM_BYTES
  assign sh_d      = {sr_q, mosi_q[1]};
  assign cnt_d     = cnt_q + CW'(1);

  assign spi_miso  = miso_q;
  assign busy      = (state_q != S_IDLE);
  assign wr_strobe = strobe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sclk_q   <= '0;
      cs_q     <= '0;
      mosi_q   <= '0;
      cnt_q    <= '0;
      sr_q     <= '0;
      out_q    <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      load_q   <= 1'b0;
      miso_q   <= 1'b0;
      strobe_q <= 1'b0;
      for (int i = 0; i < MEM_BYTES; i++) mem_q[i] <= '0;
    end else begin
      sclk_q   <= {sclk_q[1:0], spi_clk};
      cs_q     <= {cs_q[1:0], spi_cs_n};
      mosi_q   <= {mosi_q[0], spi_mosi};
      strobe_q <= 1'b0;
      // commit sits outside the deselect priority so a coincident cs rise keeps it
      if (state_q == S_WRITE && rise && last_bit) begin
        mem_q[addr_q] <= sh_d;
        strobe_q      <= 1'b1;
      end
      if (cs_rise) begin
        state_q <= S_IDLE;
        miso_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            miso_q <= 1'b0;
            if (cs_fall) begin
              state_q <= S_CMD;
              cnt_q   <= '0;
              sr_q    <= '0;
            end
          end
          S_CMD: begin
            if (rise) begin
              sr_q  <= sh_d[6:0];
              cnt_q <= cnt_d;
              if (last_bit) begin
                cnt_q <= '0;
                if (sh_d == 8'h03) begin
                  wr_q    <= 1'b0;
                  state_q <= S_ADDR;
                end else if (sh_d == 8'h02) begin
                  wr_q    <= 1'b1;
                  state_q <= S_ADDR;
                end else begin
                  state_q <= S_IGNORE;
                end
              end
            end
          end
          S_ADDR: begin
            if (rise) begin
              sr_q  <= sh_d[6:0];
              cnt_q <= cnt_d;
              if (last_addr) begin
                cnt_q   <= '0;
                addr_q  <= sh_d[AW-1:0];
                load_q  <= 1'b1;
                state_q <= wr_q ? S_WRITE : S_READ;
              end
            end
          end
          S_READ: begin
            if (rise) begin
              cnt_q <= cnt_d;
              if (last_bit) begin
                cnt_q  <= '0;
                addr_q <= addr_q + AW'(1);
                load_q <= 1'b1;
              end
            end
            if (fall) begin
              if (load_q) begin
                miso_q <= mem_q[addr_q][7];
                out_q  <= {mem_q[addr_q][6:0], 1'b0};
                load_q <= 1'b0;
              end else begin
                miso_q <= out_q[7];
                out_q  <= {out_q[6:0], 1'b0};
              end
            end
          end
          S_WRITE: begin
            if (rise) begin
              sr_q  <= sh_d[6:0];
              cnt_q <= cnt_d;
              if (last_bit) begin
                cnt_q  <= '0;
                addr_q <= addr_q + AW'(1);
              end
            end
          end
          S_IGNORE: miso_q <= 1'b0;
          default:  state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
